// File: rtl/cra_sub8_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cra_sub8_pipe
// Brief    : Two-stage pipelined ripple subtractor, d = a - b - bin, with
//            borrow-out and signed overflow; valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module cra_sub8_pipe #(
  parameter int N = 8,
  parameter int M = N / 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         ovf
);

  localparam int H = N - M;

  // Subtraction as x + ~y + c: a carry of 1 means "no borrow".
  logic [M-1:0] w_d_lo;
  logic [M:0]   w_c1;
  logic [H-1:0] w_d_hi;
  logic [H:0]   w_c2;

  logic         w_s1_load;
  logic         w_s2_load;

  logic         r_s1_valid;
  logic [M-1:0] r_d_lo;
  logic         r_c1;
  logic [H-1:0] r_a_hi;
  logic [H-1:0] r_b_hi;

  logic         r_s2_valid;
  logic [N-1:0] r_d;
  logic         r_bout;
  logic         r_ovf;

  assign w_c1[0] = ~bin;

  for (genvar i = 0; i < M; i++) begin : g_lo_slice
    assign w_d_lo[i]   = a[i] ^ ~b[i] ^ w_c1[i];
    assign w_c1[i+1]   = (a[i] & ~b[i]) | (w_c1[i] & (a[i] ^ ~b[i]));
  end

  assign w_c2[0] = r_c1;

  for (genvar j = 0; j < H; j++) begin : g_hi_slice
    assign w_d_hi[j]   = r_a_hi[j] ^ ~r_b_hi[j] ^ w_c2[j];
    assign w_c2[j+1]   = (r_a_hi[j] & ~r_b_hi[j]) | (w_c2[j] & (r_a_hi[j] ^ ~r_b_hi[j]));
  end

  // in_ready depends on out_ready but never on in_valid.
  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_s1_load = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_d_lo     <= '0;
      r_c1       <= 1'b0;
      r_a_hi     <= '0;
      r_b_hi     <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
      r_d_lo     <= w_d_lo;
      r_c1       <= w_c1[M];
      r_a_hi     <= a[N-1:M];
      r_b_hi     <= b[N-1:M];
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_d        <= '0;
      r_bout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_d        <= {w_d_hi, r_d_lo};
      r_bout     <= ~w_c2[H];
      r_ovf      <= (r_a_hi[H-1] != r_b_hi[H-1]) && (w_d_hi[H-1] != r_a_hi[H-1]);
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid = r_s2_valid;
  assign d         = r_d;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cra_sub8_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cra_sub8_pipe
// Brief    : Directed and randomized checks of cra_sub8_pipe against an
//            arithmetic reference model with an in-order expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cra_sub8_pipe;

  typedef struct packed {
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] d;
  logic       bout;
  logic       ovf;

  int   vectors = 0;
  int   miscompares = 0;
  res_t exp_q[$];
  res_t held;
  bit   hold_pending = 1'b0;
  bit   last_ov, last_ir, last_acc;

  cra_sub8_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
    int   diff, sdiff;
    res_t r;
    diff   = int'(x) - int'(y) - int'(c);
    sdiff  = int'($signed(x)) - int'($signed(y)) - int'(c);
    r.d    = 8'(diff & 255);
    r.bout = (diff < 0);
    r.ovf  = (sdiff < -128) || (sdiff > 127);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample, then let the posedge perform the handshakes.
  task automatic step(input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                      input bit ibin, input bit ordy);
    res_t e;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; bin = ibin; out_ready = ordy;
    #1;
    last_ov = out_valid;
    last_ir = in_ready;
    if (hold_pending) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'({d, bout, ovf}), 32'(held));
    end
    if (out_valid && out_ready) begin
      chk("out_unexpected", 32'(exp_q.size() == 0), 32'd0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", 32'({d, bout, ovf}), 32'(e));
      end
    end
    hold_pending = out_valid && !out_ready;
    held         = '{d: d, bout: bout, ovf: ovf};
    last_acc     = iv && in_ready;
    @(posedge clk);
    if (last_acc) exp_q.push_back(model(ia, ib, ibin));
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [7:0] ia, input logic [7:0] ib, input bit ibin);
    step(1'b1, ia, ib, ibin, 1'b1);
    chk("send_accept", 32'(last_acc), 32'd1);
    drain();
  endtask

  initial begin
    logic [7:0] opa [4];
    logic [7:0] opb [4];
    int idx, nout;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d", 32'({d, bout, ovf}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: accept, one cycle in s1, result visible on the following cycle.
    step(1'b1, 8'h50, 8'h20, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("lat_s1_only", 32'(last_ov), 32'd0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("lat_out_valid", 32'(last_ov), 32'd1);
    chk("lat_value", 32'({held.d, held.bout, held.ovf}), {22'd0, 8'h30, 2'b00});
    drain();

    send(8'h00, 8'h01, 1'b0);
    send(8'h00, 8'h00, 1'b1);
    send(8'h80, 8'h01, 1'b0);
    send(8'h7F, 8'hFF, 1'b0);
    send(8'h10, 8'h01, 1'b0);
    send(8'hFF, 8'hFF, 1'b1);

    // Backpressure: only two operands fit while the consumer stalls.
    opa = '{8'h11, 8'h22, 8'h33, 8'h44};
    opb = '{8'h05, 8'h30, 8'h01, 8'h50};
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, opa[idx], opb[idx], 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(last_ir), 32'd0);
    nout = 0;
    for (int k = 0; k < 4; k++) begin
      step(idx < 4, opa[idx & 3], opb[idx & 3], 1'b0, 1'b1);
      if (last_acc) idx++;
      if (last_ov) nout++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd4);
    chk("bp_back_to_back", 32'(nout), 32'd4);
    drain();

    // Reset with both stages full.
    step(1'b1, 8'hAA, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 8'h02, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_full", 32'(last_ov && !last_ir), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'({d, bout, ovf}), 32'd0);
    exp_q.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h05, 8'h03, 1'b1);

    // Random traffic with random stalls on both sides.
    for (int k = 0; k < 10000; k++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
